// File: rtl/crossbar_sched_2x2.sv
// -----------------------------------------------------------------------------
// crossbar_sched_2x2
//   Registered 2x2 packet crossbar. Each input word has a destination bit that
//   selects out1 (dest=0) or out2 (dest=1). Valid/ready handshakes are used on
//   all four ports. Each output has its own round-robin arbiter, and each output
//   stage holds one registered word.
//
// Ports
//   clk, rst                  clock and asynchronous active-high reset
//   inN_data/dest/valid       upstream word, destination and valid (N = 1, 2)
//   inN_ready                 the word on input N is taken at this edge
//   outK_data/valid           registered output word (K = 1, 2)
//   outK_ready                downstream K accepts the word
//   conflict_cnt              saturating count of contested arbitration cycles
// -----------------------------------------------------------------------------
module crossbar_sched_2x2 #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_dest,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [WIDTH-1:0] in2_data,
   input  logic             in2_dest,
   input  logic             in2_valid,
   output logic             in2_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [CNT_W-1:0] conflict_cnt
);

   logic [1:0]       w_out_ready;
   logic [1:0]       w_req1, w_req2;   // request from input 1/2 to each output
   logic [1:0]       w_free;           // output slot can take a word this edge
   logic [1:0]       w_acc1, w_acc2;   // word accepted from input 1/2 per output
   logic [1:0]       w_contest;
   logic [1:0]       w_valid;
   logic [WIDTH-1:0] w_data [2];
   logic [CNT_W-1:0] r_conflict_cnt;

   assign w_out_ready = {out2_ready, out1_ready};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_out
         logic             r_valid;
         logic [WIDTH-1:0] r_data;
         logic             r_prio;   // 0: input 1 wins a contest, 1: input 2 wins
         logic             w_gnt1, w_gnt2;

         assign w_req1[gi] = in1_valid && (in1_dest == 1'(gi));
         assign w_req2[gi] = in2_valid && (in2_dest == 1'(gi));
         // A slot that drains this edge may be refilled on the same edge.
         assign w_free[gi] = !r_valid || w_out_ready[gi];

         assign w_gnt1 = w_req1[gi] && (!w_req2[gi] || !r_prio);
         assign w_gnt2 = w_req2[gi] && (!w_req1[gi] ||  r_prio);

         assign w_acc1[gi]    = w_free[gi] && w_gnt1;
         assign w_acc2[gi]    = w_free[gi] && w_gnt2;
         assign w_contest[gi] = w_free[gi] && w_req1[gi] && w_req2[gi];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_valid <= 1'b0;
               r_data  <= '0;
               r_prio  <= 1'b0;
            end else if (w_free[gi]) begin
               r_valid <= w_acc1[gi] || w_acc2[gi];
               if (w_acc1[gi]) begin
                  r_data <= in1_data;
                  r_prio <= 1'b1;   // winner steps back; input 2 is favoured next
               end else if (w_acc2[gi]) begin
                  r_data <= in2_data;
                  r_prio <= 1'b0;
               end
            end
         end

         assign w_valid[gi] = r_valid;
         assign w_data[gi]  = r_data;
      end
   endgenerate

   // Only one output can be contested per cycle, so an OR is enough.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_conflict_cnt <= '0;
      end else if ((|w_contest) && (r_conflict_cnt != {CNT_W{1'b1}})) begin
         r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
   end

   // Ready is forced low while reset is held so no word is lost into a clearing slot.
   assign in1_ready = !rst && w_acc1[in1_dest];
   assign in2_ready = !rst && w_acc2[in2_dest];

   assign out1_data    = w_data[0];
   assign out1_valid   = w_valid[0];
   assign out2_data    = w_data[1];
   assign out2_valid   = w_valid[1];
   assign conflict_cnt = r_conflict_cnt;

endmodule
